// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port arbiter and fixed-latency sequencer for a
// single-ported data memory. Port 0 is the load/store path, port 1 the
// loader/DMA port. Only one access is outstanding at a time.
// Optional build macro ARB_FIXED_PRIO_EN: when defined, port 0 always wins
// contention; when undefined (default), contention is resolved round-robin.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [AW-1:0]     addr0,
    input  logic [AW-1:0]     addr1,
    input  logic [DW-1:0]     wdata0,
    input  logic [DW-1:0]     wdata1,
    input  logic [DW/8-1:0]   wstrb0,
    input  logic [DW/8-1:0]   wstrb1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DW-1:0]     rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wstrb,
    input  logic [DW-1:0]     m_rdata
);

    localparam int SW = DW / 8;
    // Counter reload value: WAIT lasts MEM_LAT cycles (counter runs down to 0).
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            sel_s;      // a winner is chosen on this edge
    logic            win_s;      // port chosen this cycle
    logic            win_r;      // port owning the outstanding access
    logic [3:0]      cnt_r;
    logic [1:0]      gnt_r;
    logic [1:0]      rvalid_r;
    logic [DW-1:0]   rdata_r;
    logic            m_en_r;
    logic            m_we_r;
    logic [AW-1:0]   m_addr_r;
    logic [DW-1:0]   m_wdata_r;
    logic [SW-1:0]   m_wstrb_r;

`ifndef ARB_FIXED_PRIO_EN
    logic            last_gnt_r;

    // Round-robin history: remember the most recent winner on every selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= 1'b1;
        end else if (sel_s) begin
            last_gnt_r <= win_s;
        end
    end
`endif

    // Winner selection: a lone requester wins; contention resolved by policy.
    always_comb begin
        win_s = 1'b0;
        if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~last_gnt_r;
`endif
        end else if (req[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state logic; arbitration happens only in IDLE and RESP.
    always_comb begin
        state_s = state_r;
        sel_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    sel_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (req != 2'b00) begin
                    sel_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Issue-side registers: on selection, latch the winner's fields so that
    // gnt/m_en/m_we are high exactly in the ISSUE cycle; m_addr/m_wdata/m_wstrb hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_r     <= 1'b0;
            gnt_r     <= 2'b00;
            m_en_r    <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= {AW{1'b0}};
            m_wdata_r <= {DW{1'b0}};
            m_wstrb_r <= {SW{1'b0}};
        end else begin
            gnt_r  <= 2'b00;
            m_en_r <= 1'b0;
            m_we_r <= 1'b0;
            if (sel_s) begin
                win_r     <= win_s;
                gnt_r     <= win_s ? 2'b10 : 2'b01;
                m_en_r    <= 1'b1;
                m_we_r    <= win_s ? we[1] : we[0];
                m_addr_r  <= win_s ? addr1 : addr0;
                m_wdata_r <= win_s ? wdata1 : wdata0;
                m_wstrb_r <= win_s ? wstrb1 : wstrb0;
            end
        end
    end

    // Latency counter and response: count down through WAIT, then capture
    // m_rdata and pulse rvalid for the owning port.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= 4'd0;
            rvalid_r <= 2'b00;
            rdata_r  <= {DW{1'b0}};
        end else begin
            rvalid_r <= 2'b00;
            if (state_r == ISSUE) begin
                cnt_r <= LAT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if ((state_r == WAIT) && (cnt_r == 4'd0)) begin
                rdata_r  <= m_rdata;
                rvalid_r <= win_r ? 2'b10 : 2'b01;
            end
        end
    end

    assign gnt     = gnt_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign m_en    = m_en_r;
    assign m_we    = m_we_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;
    assign m_wstrb = m_wstrb_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported RV32I data memory. It shares the memory between the processor's load/store path (port 0) and a program loader/DMA port (port 1), one outstanding access at a time. It applies round-robin priority and drives the memory through a fixed-latency access sequence. Each requester receives a one-cycle grant pulse and a one-cycle response pulse.

## Interface
- AW, 32: address width in bits.
- DW, 32: data width in bits; byte-strobe width is DW/8.
- MEM_LAT, 1: memory read latency in cycles, from the m_en cycle to the cycle m_rdata is valid; legal range 1..15.

Ports (clk and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-port request; bit i belongs to port i.
- we  in  2  per-port write enable (1 = write, 0 = read).
- addr0 / addr1  in  AW  per-port byte address.
- wdata0 / wdata1  in  DW  per-port write data.
- wstrb0 / wstrb1  in  DW/8  per-port byte enables (writes only).
- gnt  out  2  one-hot, one-cycle grant pulse.
- rvalid  out  2  one-hot, one-cycle completion pulse; also acknowledges writes.
- rdata  out  DW  read data, valid while either rvalid bit is 1.
- m_en  out  1  memory access strobe, one cycle.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_wstrb  out  DW/8  memory byte enables.
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en.

## Operation
- FSM states:
  - IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - if req != 0, select a winner and go to ISSUE.
  - on that edge, register the winner's we/addr/wdata/wstrb into the m_* outputs.
- ISSUE:
  - m_en=1 and gnt[winner]=1 for exactly this cycle.
  - load the latency counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - decrement the counter each cycle.
  - when the counter is 0, capture m_rdata into the rdata register and go to RESP.
  - with MEM_LAT=1, WAIT lasts one cycle.
- RESP:
  - rvalid[winner]=1.
  - if req != 0, arbitrate again and go directly to ISSUE; otherwise go to IDLE.
- Arbitration (round-robin):
  - a one-bit last_gnt register records the most recent winner.
  - if both ports request, the port != last_gnt wins.
  - if only one port requests, that port wins.
  - last_gnt updates on every selection; its reset value is 1, so port 0 wins the first contention.
- Requester rules:
  - hold req and all fields stable until gnt is seen.
  - fields are sampled only at the selection edge.
  - a port may keep req high after gnt to queue its next access; that access is a new transaction subject to arbitration.
- Writes:
  - rdata is still updated from m_rdata; its content is don't-care for writes.
  - rvalid still pulses as the write acknowledge.
- m_* outputs hold their last value between transactions; m_en/m_we are 0 outside ISSUE.

## Timing
- Reset values:
  - state=IDLE, last_gnt=1, counter=0.
  - gnt=0, rvalid=0, rdata=0.
  - m_en=0, m_we=0, m_addr=0, m_wdata=0, m_wstrb=0.
- Latency, with req high in cycle N while IDLE:
  - gnt and m_en in cycle N+1.
  - m_rdata captured at the end of cycle N+1+MEM_LAT.
  - rvalid in cycle N+2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles; the next gnt comes the cycle after RESP.
- A req asserted during ISSUE or WAIT is not seen until RESP. No request is dropped while req stays high.
- Reset asserted mid-transaction returns to IDLE next cycle:
  - the in-flight access is abandoned; no rvalid is issued for it.
  - the memory write may already have occurred if reset arrives after ISSUE.
- req with gnt pulses never overlaps a pending rvalid for the other port: one outstanding transaction system-wide.

## Configuration
- ARB_FIXED_PRIO_EN:
  - defined: fixed priority; port 0 always wins when both request; last_gnt is unused.
  - undefined (default): round-robin as described above.

## Test plan
- Single read, MEM_LAT=1, memory word 0x10 = 0xDEADBEEF. Port 0 req, we=0, addr=0x10 in cycle 0 -> gnt[0] cycle 1, m_en=1, m_addr=0x10 in cycle 1, rvalid[0] cycle 3, rdata=0xDEADBEEF.
- Write then read, MEM_LAT=3. Port 1 writes 0x12345678 with wstrb=4'b0011 to 0x20 (prior content 0xAAAAAAAA) -> rvalid[1] at cycle 5. Port 1 then reads 0x20 -> rdata=0xAAAA5678.
- Contention after reset, both req held high -> grants in order 0,1,0,1, each spaced MEM_LAT+2 cycles apart. With ARB_FIXED_PRIO_EN -> port 0 wins every grant while its req stays high.
- Port 1 requests during port 0's WAIT -> port 1 is granted the cycle after rvalid[0]. Never more than one m_en per transaction.
- Reset asserted for one cycle during WAIT -> no rvalid, all outputs at reset values next cycle. A fresh port 1 request then completes normally.
- Randomized mix of reads and writes from both ports against a reference memory model -> every gnt is matched by exactly one rvalid to the same port. Read data matches the model.
